// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: decode-side control/results and the instruction
// memory read port. The fetch unit sits on the master side; the decode stage
// and instruction memory (or a test harness) sit on the slave side.
interface fetch_unit_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
        output imem_en_o, imem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
        input  imem_en_o, imem_addr_o, valid_o, instr_o, pc_o, pc_plus4_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and buffers returned words in a small FIFO whose head is
// the IF/ID register. Redirects flush everything, including the read in flight.

// Protocol checker: a response must never be pushed into a full buffer.
module fetch_unit_checker #(
    parameter int DEPTH = 2,
    parameter int OW    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          push_i,
    input logic [OW-1:0] occ_i
);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        push_i |-> (occ_i != FULL_OCC))
        else $error("fetch_unit: push into full buffer (occ=%0d)", occ_i);
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_unit_if.master mif
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int LW = OW + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic [OW-1:0] occ_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   buf_pc_r    [DEPTH];
    logic [31:0]   buf_instr_r [DEPTH];

    logic          valid_s;
    logic          deq_s;
    logic          push_s;
    logic          issue_s;
    logic [LW-1:0] level_s;
    logic          unused_lsb_s;

    // Low address bits of the redirect target are ignored by design.
    assign unused_lsb_s = ^mif.redirect_pc_i[1:0];

    // Handshake decode: dequeue, response push and issue gating.
    always_comb begin
        valid_s = (occ_r != {OW{1'b0}});
        deq_s   = valid_s & ~mif.stall_i;
        push_s  = inflight_r & ~mif.redirect_i;
        // Entries committed after this cycle, counting the read in flight.
        level_s = {1'b0, occ_r} + {{OW{1'b0}}, inflight_r} - {{OW{1'b0}}, deq_s};
        if ((level_s < DEPTH_LVL) && !rst_i && !mif.redirect_i) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // PC, in-flight tracking, pointers and occupancy; redirect flushes all.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            occ_r         <= {OW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
        end else if (mif.redirect_i) begin
            fetch_pc_r    <= {mif.redirect_pc_i[31:2], 2'b00};
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
            occ_r         <= {OW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + 32'd4;
                inflight_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, deq_s})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Buffer storage: capture {pc, instr} of each accepted response.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_s) begin
            buf_pc_r[wr_ptr_r]    <= inflight_pc_r;
            buf_instr_r[wr_ptr_r] <= mif.imem_data_i;
        end
    end

    // Output drive: memory request plus head entry, forced to zero when empty.
    always_comb begin
        mif.imem_en_o   = issue_s;
        mif.imem_addr_o = fetch_pc_r;
        mif.valid_o     = valid_s;
        if (valid_s) begin
            mif.instr_o    = buf_instr_r[rd_ptr_r];
            mif.pc_o       = buf_pc_r[rd_ptr_r];
            mif.pc_plus4_o = buf_pc_r[rd_ptr_r] + 32'd4;
        end else begin
            mif.instr_o    = 32'h0000_0000;
            mif.pc_o       = 32'h0000_0000;
            mif.pc_plus4_o = 32'h0000_0000;
        end
    end

    fetch_unit_checker #(.DEPTH(DEPTH), .OW(OW)) u_checker (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_s),
        .occ_i  (occ_r)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free run, stall, redirect, redirect+stall,
// PC wrap (second instance) and mid-run reset. Memory returns word = address.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;

    fetch_unit_if fa ();
    fetch_unit_if fb ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
        .clk_i (clk), .rst_i (rst), .mif (fa.master)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
        .clk_i (clk), .rst_i (rst), .mif (fb.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memories: data = address, one cycle after enable.
    always @(posedge clk) begin
        if (fa.imem_en_o) fa.imem_data_i <= fa.imem_addr_o;
        if (fb.imem_en_o) fb.imem_data_i <= fb.imem_addr_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head_a(input string tag, input logic v, input logic [31:0] p);
        logic [31:0] p4;
        p4 = p + 32'd4;
        chk({tag, "_valid"}, {31'd0, fa.valid_o}, {31'd0, v});
        chk({tag, "_pc"},    fa.pc_o,       v ? p  : 32'h0);
        chk({tag, "_instr"}, fa.instr_o,    v ? p  : 32'h0);
        chk({tag, "_pc4"},   fa.pc_plus4_o, v ? p4 : 32'h0);
    endtask

    task automatic head_b(input string tag, input logic [31:0] p);
        logic [31:0] p4;
        p4 = p + 32'd4;
        chk({tag, "_valid"}, {31'd0, fb.valid_o}, 32'd1);
        chk({tag, "_pc"},    fb.pc_o,       p);
        chk({tag, "_instr"}, fb.instr_o,    p);
        chk({tag, "_pc4"},   fb.pc_plus4_o, p4);
    endtask

    task automatic issue_a(input string tag, input logic en, input logic [31:0] addr);
        chk({tag, "_en"}, {31'd0, fa.imem_en_o}, {31'd0, en});
        if (en) chk({tag, "_addr"}, fa.imem_addr_o, addr);
    endtask

    initial begin
        fa.stall_i = 1'b0; fa.redirect_i = 1'b0; fa.redirect_pc_i = 32'h0; fa.imem_data_i = 32'h0;
        fb.stall_i = 1'b0; fb.redirect_i = 1'b0; fb.redirect_pc_i = 32'h0; fb.imem_data_i = 32'h0;

        // Reset state
        repeat (3) tick();
        issue_a("rst", 1'b0, 32'h0);
        chk("rst_b_en", {31'd0, fb.imem_en_o}, 32'd0);
        head_a("rst", 1'b0, 32'h0);

        // Cycle 0: first fetch at RESET_PC
        rst = 1'b0;
        #1;
        issue_a("c0", 1'b1, 32'h0);
        chk("c0_b_en", {31'd0, fb.imem_en_o}, 32'd1);
        chk("c0_b_addr", fb.imem_addr_o, 32'hFFFF_FFF8);
        tick();
        head_a("c1", 1'b0, 32'h0);
        issue_a("c1", 1'b1, 32'h4);
        tick();

        // Cycles 2..5: one instruction per cycle; B wraps through 0
        for (int i = 0; i < 4; i++) begin
            head_a("run", 1'b1, 32'(4 * i));
            if (i < 3) head_b("wrap", 32'hFFFF_FFF8 + 32'(4 * i));
            if (i == 1) chk("wrap_pc4_zero", fb.pc_plus4_o, 32'h0);
            tick();
        end

        // Cycles 6..10: stall with head at 0x10
        fa.stall_i = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            head_a("stall", 1'b1, 32'h10);
            en_cnt += int'(fa.imem_en_o);
            if (k == 4) issue_a("stall_last", 1'b0, 32'h0);
            tick();
        end
        chk("stall_issue_le1", {31'd0, (en_cnt <= 1)}, 32'd1);

        // Cycles 11..13: release, no bubble
        fa.stall_i = 1'b0;
        #1;
        issue_a("release", 1'b1, 32'h18);
        head_a("rel0", 1'b1, 32'h10);
        tick();
        head_a("rel1", 1'b1, 32'h14);
        tick();
        head_a("rel2", 1'b1, 32'h18);

        // Redirect to 0x103 with a read in flight
        fa.redirect_i = 1'b1;
        fa.redirect_pc_i = 32'h0000_0103;
        #1;
        issue_a("redir", 1'b0, 32'h0);
        tick();
        fa.redirect_i = 1'b0;
        #1;
        head_a("redir_n1", 1'b0, 32'h0);
        issue_a("redir_n1", 1'b1, 32'h100);
        tick();
        head_a("redir_n2", 1'b0, 32'h0);
        tick();
        head_a("redir_n3", 1'b1, 32'h100);
        tick();
        head_a("redir_n4", 1'b1, 32'h104);

        // Redirect and stall together with a full buffer
        fa.stall_i = 1'b1;
        tick();
        head_a("full_hold", 1'b1, 32'h104);
        fa.redirect_i = 1'b1;
        fa.redirect_pc_i = 32'h0000_0200;
        #1;
        issue_a("rs", 1'b0, 32'h0);
        tick();
        fa.redirect_i = 1'b0;
        fa.stall_i = 1'b0;
        #1;
        head_a("rs_n1", 1'b0, 32'h0);
        issue_a("rs_n1", 1'b1, 32'h200);
        tick();
        head_a("rs_n2", 1'b0, 32'h0);
        tick();
        head_a("rs_n3", 1'b1, 32'h200);
        tick();
        head_a("rs_n4", 1'b1, 32'h204);

        // Reset pulse with a full buffer
        fa.stall_i = 1'b1;
        tick();
        head_a("pre_rst", 1'b1, 32'h204);
        rst = 1'b1;
        #1;
        issue_a("mid_rst", 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        fa.stall_i = 1'b0;
        #1;
        head_a("post_rst1", 1'b0, 32'h0);
        issue_a("post_rst1", 1'b1, 32'h0);
        tick();
        head_a("post_rst2", 1'b0, 32'h0);
        tick();
        head_a("post_rst3", 1'b1, 32'h0);
        tick();
        head_a("post_rst4", 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
